// File: rtl/rr_vc_alloc_ctrl_pkg.sv
// Shared types and helpers for the round-robin VC allocator.
// The state encoding is fixed: IDLE = 0, LOCKED = 1.
package rr_vc_alloc_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Ceiling log2; also gives the index width for a power-of-two VC count.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_vc_alloc_ctrl_if.sv
// Request/grant bundle between the VC requesters of one VN and the allocator.
// There is no ready/valid pair here. A grant is valid while grant_valid_out is
// high, and it stays constant until a cycle in which xfer_in and tail_in are
// both high. While grant_valid_out is low, xfer_in and tail_in are ignored.
interface rr_vc_alloc_ctrl_if #(
  parameter int NUM_VC = 4
);
  import rr_vc_alloc_ctrl_pkg::*;
  localparam int BITS_VC = log2(NUM_VC);

  logic [NUM_VC-1:0]  req_in;
  logic               avail_in;
  logic               xfer_in;
  logic               tail_in;
  logic [NUM_VC-1:0]  grant_out;
  logic               grant_valid_out;
  logic [BITS_VC-1:0] grant_id_out;
  logic               busy_out;

  modport master (
    output req_in, avail_in, xfer_in, tail_in,
    input  grant_out, grant_valid_out, grant_id_out, busy_out
  );

  modport slave (
    input  req_in, avail_in, xfer_in, tail_in,
    output grant_out, grant_valid_out, grant_id_out, busy_out
  );
endinterface

// File: rtl/rr_vc_alloc_ctrl_rotl.sv
// Purely combinational rotate-left of a W-bit vector by i_shamt positions.
module rr_vc_alloc_ctrl_rotl #(
  parameter int W   = 4,
  parameter int SHW = 2
) (
  input  logic [W-1:0]   i_data,
  input  logic [SHW-1:0] i_shamt,
  output logic [W-1:0]   o_data
);
  logic [2*W-1:0] w_dbl;

  // The upper half of the doubled, shifted word is the rotated value.
  assign w_dbl  = {i_data, i_data} << i_shamt;
  assign o_data = w_dbl[2*W-1:W];
endmodule

// File: rtl/rr_vc_alloc_ctrl.sv
// Round-robin allocator for one output resource. A grant is locked for a whole
// packet and released on the transferred tail flit. The VC that was just served gets lowest priority next.
module rr_vc_alloc_ctrl
  import rr_vc_alloc_ctrl_pkg::*;
#(
  parameter int NUM_VC  = 4,
  parameter int NUM_VN  = 3,
  parameter int bits_VC = log2(NUM_VC)
) (
  input  logic               clk,
  input  logic               rst,
  rr_vc_alloc_ctrl_if.slave  bus,
  output state_t             o_dbg_state,
  output logic [bits_VC-1:0] o_dbg_ptr
);

  if (NUM_VC < 2 || (NUM_VC & (NUM_VC - 1)) != 0 || NUM_VN < 1) begin : g_param_check
    $error("rr_vc_alloc_ctrl: NUM_VC must be a power of two >= 2 and NUM_VN >= 1");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [bits_VC-1:0] r_ptr;
  logic [bits_VC-1:0] w_ptr_nxt;
  logic [NUM_VC-1:0]  r_grant;
  logic [NUM_VC-1:0]  w_grant_nxt;
  logic [bits_VC-1:0] r_grant_id;
  logic [bits_VC-1:0] w_grant_id_nxt;

  logic [bits_VC-1:0] w_rshamt;
  logic [NUM_VC-1:0]  w_rot;
  logic [bits_VC-1:0] w_k;
  logic [NUM_VC-1:0]  w_k_oh;
  logic [NUM_VC-1:0]  w_win_oh;
  logic [bits_VC-1:0] w_win_id;

  // A right rotation by ptr is a left rotation by -ptr modulo NUM_VC.
  assign w_rshamt = '0 - r_ptr;

  rr_vc_alloc_ctrl_rotl #(.W(NUM_VC), .SHW(bits_VC)) u_rot_req (
    .i_data  (bus.req_in),
    .i_shamt (w_rshamt),
    .o_data  (w_rot)
  );

  always_comb begin
    w_k = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_k = bits_VC'(i);
    end
  end

  assign w_k_oh   = NUM_VC'(1) << w_k;
  assign w_win_id = w_k + r_ptr;

  rr_vc_alloc_ctrl_rotl #(.W(NUM_VC), .SHW(bits_VC)) u_rot_win (
    .i_data  (w_k_oh),
    .i_shamt (r_ptr),
    .o_data  (w_win_oh)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    case (r_state)
      IDLE: begin
        if ((|bus.req_in) && bus.avail_in) begin
          w_state_nxt    = LOCKED;
          w_grant_nxt    = w_win_oh;
          w_grant_id_nxt = w_win_id;
        end
      end
      LOCKED: begin
        // Requests and avail are deliberately ignored until the tail is transferred.
        if (bus.xfer_in && bus.tail_in) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_ptr_nxt      = r_grant_id + bits_VC'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  assign bus.grant_out       = r_grant;
  assign bus.grant_valid_out = |r_grant;
  assign bus.grant_id_out    = r_grant_id;
  assign bus.busy_out        = (r_state == LOCKED);
  assign o_dbg_state         = r_state;
  assign o_dbg_ptr           = r_ptr;

endmodule

// File: tb/tb_rr_vc_alloc_ctrl.sv
// Bench for rr_vc_alloc_ctrl with NUM_VC=4: directed scenarios, then random traffic.
// A cycle-level reference model predicts the outputs.
module tb_rr_vc_alloc_ctrl;
  import rr_vc_alloc_ctrl_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  state_t     dbg_state;
  logic [1:0] dbg_ptr;

  int total = 0;
  int bad   = 0;

  // Reference model: lock flag, locked VC, and round-robin start point.
  bit m_locked;
  int m_id;
  int m_ptr;

  rr_vc_alloc_ctrl_if #(.NUM_VC(N)) bus ();

  rr_vc_alloc_ctrl #(.NUM_VC(N), .NUM_VN(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] exp_grant;
    exp_grant = m_locked ? (32'd1 << m_id) : 32'd0;
    chk({tag, ".grant"}, 32'(bus.grant_out), exp_grant);
    chk({tag, ".valid"}, 32'(bus.grant_valid_out), 32'(m_locked));
    chk({tag, ".id"}, 32'(bus.grant_id_out), m_locked ? 32'(m_id) : 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy_out), 32'(m_locked));
    chk({tag, ".ptr"}, 32'(dbg_ptr), 32'(m_ptr));
    chk({tag, ".state"}, 32'(dbg_state), 32'(m_locked));
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_id     = 0;
    m_ptr    = 0;
  endtask

  // Drive one cycle of inputs, step the model, then check the outputs just after the edge.
  task automatic cycle(input logic [3:0] req, input logic avail, input logic xfer,
                       input logic tail, input string tag);
    bit n_locked;
    int n_id;
    int n_ptr;
    bit found;
    bus.req_in   = req;
    bus.avail_in = avail;
    bus.xfer_in  = xfer;
    bus.tail_in  = tail;
    n_locked = m_locked;
    n_id     = m_id;
    n_ptr    = m_ptr;
    if (!m_locked) begin
      if (req != 4'b0 && avail) begin
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (!found && req[(m_ptr + j) % N]) begin
            found    = 1'b1;
            n_id     = (m_ptr + j) % N;
            n_locked = 1'b1;
          end
        end
      end
    end else if (xfer && tail) begin
      n_locked = 1'b0;
      n_ptr    = (m_id + 1) % N;
    end
    @(posedge clk);
    #1;
    m_locked = n_locked;
    m_id     = n_id;
    m_ptr    = n_ptr;
    chk_model(tag);
  endtask

  initial begin
    rst          = 1'b1;
    bus.req_in   = '0;
    bus.avail_in = 1'b0;
    bus.xfer_in  = 1'b0;
    bus.tail_in  = 1'b0;
    model_reset();
    #12;
    chk_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full load: VC0 first, release, bubble, then VC1.
    cycle(4'b1111, 1, 0, 0, "full_c1");
    chk("full_c1_lit", 32'(bus.grant_out), 32'b0001);
    cycle(4'b1111, 1, 0, 0, "full_c2");
    cycle(4'b1111, 1, 1, 1, "full_rel");
    cycle(4'b1111, 1, 0, 0, "full_next");
    chk("full_next_lit", 32'(bus.grant_out), 32'b0010);

    // Wrap-around: serve VC2 so ptr=3, then 0011 must pick VC0.
    cycle(4'b0000, 1, 1, 1, "wrap_rel1");
    cycle(4'b0100, 1, 0, 0, "wrap_vc2");
    cycle(4'b0000, 1, 1, 1, "wrap_rel2");
    chk("wrap_ptr3", 32'(dbg_ptr), 32'd3);
    cycle(4'b0011, 1, 0, 0, "wrap_vc0");
    chk("wrap_vc0_lit", 32'(bus.grant_out), 32'b0001);
    cycle(4'b0000, 1, 1, 1, "wrap_rel3");
    cycle(4'b1000, 1, 0, 0, "wrap_vc3");
    cycle(4'b0000, 1, 1, 1, "wrap_rel4");
    chk("wrap_ptr0", 32'(dbg_ptr), 32'd0);

    // Lock hold against dropped request and body flits.
    cycle(4'b0010, 1, 0, 0, "hold_grant");
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 0, 1, 0, "hold_body");
      chk("hold_lit", 32'(bus.grant_out), 32'b0010);
    end
    cycle(4'b0000, 1, 1, 1, "hold_rel");

    // avail_in gating.
    cycle(4'b0100, 0, 0, 0, "avail_lo1");
    cycle(4'b0100, 0, 0, 0, "avail_lo2");
    cycle(4'b0100, 1, 0, 0, "avail_hi");
    chk("avail_lit", 32'(bus.grant_out), 32'b0100);

    // Spurious tail while locked, spurious xfer+tail while idle.
    cycle(4'b0000, 1, 0, 1, "spur_tail");
    cycle(4'b0000, 1, 1, 1, "spur_rel");
    cycle(4'b0000, 1, 1, 1, "spur_idle1");
    cycle(4'b0000, 0, 1, 1, "spur_idle2");

    // Asynchronous reset while VC3 holds the grant.
    cycle(4'b1000, 1, 0, 0, "rst_grant");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_model("rst_async");
    #1;
    rst = 1'b0;
    cycle(4'b1000, 1, 0, 0, "rst_regrant");
    chk("rst_regrant_lit", 32'(bus.grant_out), 32'b1000);
    cycle(4'b0000, 1, 1, 1, "rst_rel");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_vc_alloc_ctrl.md
Name: rr_vc_alloc_ctrl

Overview:
- Sequential round-robin allocator that shares one output resource (switch output or downstream VC slot) among NUM_VC virtual-channel requesters of one virtual network in the 2D-mesh VC switch.
- Arbitrates among requests, locks the grant for a whole packet (wormhole) and releases it on the transferred tail flit.
- Advances a rotating priority pointer so the just-served VC has lowest priority in the next round.
- One instance sits per output port per VN, next to the port's crossbar select logic.

Parameters:
- NUM_VC, 4, number of VCs per VN; power of two, >= 2.
- NUM_VN, 3, number of VNs; carried for uniformity, not used internally.
- bits_VC, Log2(NUM_VC), localparam; width of the VC index.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  NUM_VC  bit i set: VC i requests the resource.
- avail_in  in  1  resource free, allowed to start a new allocation.
- xfer_in  in  1  a flit of the granted VC is transferred this cycle.
- tail_in  in  1  the flit qualified by xfer_in is a tail flit.
- grant_out  out  NUM_VC  one-hot grant, registered.
- grant_valid_out  out  1  grant_out is valid (OR of grant_out).
- grant_id_out  out  bits_VC  binary index of the granted VC.
- busy_out  out  1  FSM in LOCKED.

Behaviour:
- Reset (asynchronous, active-high) values:
  - grant_out = 0, grant_valid_out = 0, grant_id_out = 0, busy_out = 0.
  - ptr = 0, state = IDLE.
  - Reset mid-packet drops the lock immediately; no release event is generated.
- State IDLE:
  - If (|req_in) && avail_in, then on the next edge: state becomes LOCKED and grant_out/grant_id_out/grant_valid_out are loaded.
  - Latency from request to grant is 1 cycle.
  - Otherwise stay in IDLE with all outputs 0.
- Arbitration (combinational, evaluated only in IDLE):
  - rot = req_in rotated right by ptr, so that ptr maps to bit 0.
  - Pick the lowest set bit of rot: priority encoder giving index k.
  - Winner one-hot = rotate left of the one-hot(k) by ptr; winner id = (k + ptr) mod NUM_VC, kept to bits_VC bits.
  - Search order is ptr, ptr+1, ..., NUM_VC-1, 0, ..., ptr-1.
- State LOCKED:
  - Grant outputs held constant.
  - req_in and avail_in are ignored, including when the granted VC drops its request.
  - xfer_in && tail_in: the next edge enters IDLE, clears the grant outputs and sets ptr = (grant_id_out + 1) mod NUM_VC. NUM_VC-1 wraps to 0.
  - xfer_in without tail_in: no state change.
  - tail_in without xfer_in: ignored.
- Boundary rules:
  - Release and new requests in the same cycle: the new arbitration happens in the IDLE cycle after release. This guarantees at least one bubble cycle between packets, even for the same VC.
  - xfer_in or tail_in while IDLE: ignored.
  - ptr changes only on release.
  - grant_out is always one-hot or zero.

Decomposition:
- Shared package/header:
  - Log2 from common_functions.vh.
  - State encoding constants IDLE=1'b0, LOCKED=1'b1.
- One sub-module: the existing NUM_VC-wide rotate-left block, instantiated for the return rotation.
  - The right rotation is done inline as rotate left by (NUM_VC - ptr) mod NUM_VC.
  - That rotation is either a second instance of the same block or inline logic; NUM_VC is a power of two, so the mod is a bits_VC truncation.
- FSM, ptr register and priority encoder stay in this module.

Test Plan:
- All tests use NUM_VC=4.
- Full load: after reset, req_in=1111, avail_in=1.
  - -> grant_out=0001 and grant_id_out=0 at cycle 1, busy_out=1.
  - xfer+tail at cycle 3 -> grant 0 in cycle 4, then grant_out=0010 at cycle 5.
- Wrap-around: serve VC2 so ptr=3, then req_in=0011 -> grant_out=0001 (VC0), not VC1. Serve VC3 -> ptr=0.
- Lock hold: grant VC1, then req_in=0000 and xfer without tail for 5 cycles -> grant_out stays 0010 and busy_out=1. The tail releases it.
- avail_in=0 with req_in=0100 -> grant_out stays 0. When avail_in goes to 1 -> grant_out=0100 one cycle later.
- Spurious inputs:
  - tail_in=1 with xfer_in=0 while LOCKED -> no release.
  - xfer_in=tail_in=1 while IDLE -> no ptr change.
- Reset mid-lock: assert rst asynchronously between edges while VC3 is granted -> outputs 0 immediately and ptr=0. After rst is deasserted with req_in=1000 -> VC3 is granted at the next edge.
